// File: rtl/store_checker_pkg.sv
// Shared types and constants for the store_checker self-check monitor.
// Optional feature macro: STORE_CHECKER_ORDERED_EN (in-order matching rule).
package store_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_BAD_DATA = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;
  localparam logic [1:0] FC_ORDER    = 2'd3;

  // Width of fail_idx / next_idx and the largest supported table size.
  localparam int IDX_W      = 4;
  localparam int MAX_CHECKS = 16;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_CHECKS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = MAX_CHECKS - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/store_check_slot.sv
// One expected address/data entry: latches the pair on load and reports
// whether the current store hits its address and carries the expected data.
module store_check_slot
  import store_checker_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              addr_hit,
  output logic              data_ok
);

  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic [DATA_W-1:0] exp_data_q, exp_data_d;

  // Capture a fresh expected pair only when the checker is armed.
  always_comb begin
    exp_addr_d = exp_addr_q;
    exp_data_d = exp_data_q;
    if (load) begin
      exp_addr_d = load_addr;
      exp_data_d = load_data;
    end
  end

  // Expected-pair storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_addr_q <= '0;
      exp_data_q <= '0;
    end else begin
      exp_addr_q <= exp_addr_d;
      exp_data_q <= exp_data_d;
    end
  end

  assign addr_hit = (wr_addr == exp_addr_q);
  assign data_ok  = (wr_data == exp_data_q);

endmodule

// File: rtl/store_checker.sv
// Store self-check monitor: compares committed stores against a table of
// expected address/data pairs under a cycle budget and holds a sticky
// PASS/FAIL verdict. Define STORE_CHECKER_ORDERED_EN to require that the
// entries match in index order.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int NUM_CHECKS = 4,
  parameter int MAX_CYCLES = 100,
  parameter int CYC_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_CHECKS*ADDR_W-1:0] exp_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0] exp_data,
  input  logic                         wr_valid,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [1:0]                   fail_code,
  output logic [IDX_W-1:0]             fail_idx,
  output logic [NUM_CHECKS-1:0]        match_mask,
  output logic [CYC_W-1:0]             cycle_count
);

  state_e                state_q, state_d;
  logic [NUM_CHECKS-1:0] mask_q, mask_d;
  logic [CYC_W-1:0]      count_q, count_d, count_inc;
  logic [1:0]            code_q, code_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic [NUM_CHECKS-1:0] addr_hit, data_ok;
  logic [NUM_CHECKS-1:0] hit_vec, good_vec, bad_vec, mask_next, order_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHECKS; gi++) begin : g_slot
      store_check_slot #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
      ) u_slot (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .load_addr(exp_addr[gi*ADDR_W +: ADDR_W]),
        .load_data(exp_data[gi*DATA_W +: DATA_W]),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .addr_hit (addr_hit[gi]),
        .data_ok  (data_ok[gi])
      );
    end
  endgenerate

  // Per-entry classification of this cycle's store.
  assign hit_vec   = wr_valid ? addr_hit : '0;
  assign good_vec  = hit_vec & data_ok;
  assign bad_vec   = hit_vec & ~data_ok;
  assign mask_next = mask_q | good_vec;

`ifdef STORE_CHECKER_ORDERED_EN
  logic [IDX_W-1:0] next_idx_q, next_idx_d;

  // A correct store to a still-open entry above the lowest open one is out of order.
  generate
    for (gi = 0; gi < NUM_CHECKS; gi++) begin : g_order
      assign order_vec[gi] = good_vec[gi] & ~mask_q[gi] & (IDX_W'(gi) > next_idx_q);
    end
  endgenerate

  // Track the lowest entry that has not matched yet.
  always_comb begin
    next_idx_d = next_idx_q;
    if (start) begin
      next_idx_d = '0;
    end else if (state_q == ST_RUN) begin
      next_idx_d = lowest_set(~(MAX_CHECKS'(mask_next)));
    end
  end

  // Lowest-open-entry register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) next_idx_q <= '0;
    else       next_idx_q <= next_idx_d;
  end
`else
  assign order_vec = '0;
`endif

  // Next-state, counter and verdict; priority BAD_DATA > ORDER > PASS > TIMEOUT.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    count_d   = count_q;
    code_d    = code_q;
    idx_d     = idx_q;
    count_inc = count_q + 1'b1;
    if (start) begin
      state_d = ST_RUN;
      mask_d  = '0;
      count_d = '0;
      code_d  = FC_NONE;
      idx_d   = '0;
    end else if (state_q == ST_RUN) begin
      count_d = count_inc;
      mask_d  = mask_next;
      if (|bad_vec) begin
        state_d = ST_FAIL;
        code_d  = FC_BAD_DATA;
        idx_d   = lowest_set(MAX_CHECKS'(bad_vec));
      end else if (|order_vec) begin
        state_d = ST_FAIL;
        code_d  = FC_ORDER;
        idx_d   = lowest_set(MAX_CHECKS'(order_vec));
      end else if (&mask_next) begin
        state_d = ST_PASS;
      end else if (count_inc == CYC_W'(MAX_CYCLES)) begin
        state_d = ST_FAIL;
        code_d  = FC_TIMEOUT;
        idx_d   = '0;
      end
    end
  end

  // State, mask, counter and verdict registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      count_q <= '0;
      code_q  <= FC_NONE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
    end
  end

  assign done        = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass        = (state_q == ST_PASS);
  assign fail        = (state_q == ST_FAIL);
  assign fail_code   = code_q;
  assign fail_idx    = idx_q;
  assign match_mask  = mask_q;
  assign cycle_count = count_q;

endmodule
